// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// ---------------
// Sequences one RV32I load/store at a time against a word-wide, single-port
// data memory with a one-cycle synchronous read. Sub-word stores are done as
// read-modify-write so untouched bytes are preserved; loads are lane-selected
// and sign/zero-extended. Misaligned or illegal accesses complete in one cycle
// with rsp_fault=1 and never touch memory.
//
// Handshake: a request is accepted on the rising edge where
// req_valid && req_ready; req_ready is high only in IDLE. req_* are sampled
// only at that edge and ignored otherwise. Completion is a single-cycle
// rsp_valid pulse with rsp_rdata/rsp_fault valid in that cycle; there is no
// backpressure on the response.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    request handshake
//   req_write, req_funct3    operation (store flag + RV32I funct3)
//   req_addr, req_wdata      byte address, LSB-justified store data
//   rsp_valid, rsp_rdata,    completion pulse, extended load data,
//   rsp_fault                misaligned/illegal flag
//   mem_addr, mem_we,        word-aligned memory address, write enable,
//   mem_wdata, mem_rdata     write word, read word (valid cycle after address)

module mem_access_ctrl #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_fault,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RD_WAIT = 3'd2,
        WR      = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                state;
    logic                  wr_q;
    logic [2:0]            f3_q;
    logic [1:0]            lane_q;
    logic [15:0]           wdata_q;   // only the low half is ever merged
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [31:0]           word_q;    // word to write (SW data or merged RMW word)
    logic [31:0]           rdata_q;
    logic                  fault_q;

    logic                  req_fault;
    logic [7:0]            sel_byte;
    logic [15:0]           sel_half;
    logic [31:0]           load_ext;
    logic [31:0]           merged;

    // Fault decode on the live request, used only at the accept edge.
    always_comb begin
        req_fault = 1'b0;
        if (req_write) begin
            req_fault = req_funct3[2] | (req_funct3[1:0] == 2'b11);
        end else begin
            req_fault = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                        (req_funct3 == 3'b111);
        end
        if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) begin
            req_fault = 1'b1;
        end
        if ((req_funct3[1:0] == 2'b01) && req_addr[0]) begin
            req_fault = 1'b1;
        end
    end

    // Lane select and extension of the word arriving in RD_WAIT.
    always_comb begin
        sel_byte = mem_rdata[{lane_q, 3'b000} +: 8];
        sel_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  load_ext = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  load_ext = {24'h000000, sel_byte};
            3'b001:  load_ext = {{16{sel_half[15]}}, sel_half};
            3'b101:  load_ext = {16'h0000, sel_half};
            default: load_ext = mem_rdata;
        endcase
    end

    // Read-modify-write merge: replace only the addressed lane(s).
    always_comb begin
        merged = mem_rdata;
        if (f3_q[1:0] == 2'b00) begin
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            wr_q    <= 1'b0;
            f3_q    <= 3'b000;
            lane_q  <= 2'b00;
            wdata_q <= 16'h0000;
            waddr_q <= '0;
            word_q  <= 32'h0;
            rdata_q <= 32'h0;
            fault_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wr_q    <= req_write;
                        f3_q    <= req_funct3;
                        lane_q  <= req_addr[1:0];
                        wdata_q <= req_wdata[15:0];
                        waddr_q <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        word_q  <= req_wdata;
                        rdata_q <= 32'h0;
                        fault_q <= req_fault;
                        if (req_fault) begin
                            state <= DONE;
                        end else if (req_write && (req_funct3[1:0] == 2'b10)) begin
                            state <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: state <= RD_WAIT;
                RD_WAIT: begin
                    if (wr_q) begin
                        word_q <= merged;
                        state  <= WR;
                    end else begin
                        rdata_q <= load_ext;
                        state   <= DONE;
                    end
                end
                WR:      state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign mem_we    = (state == WR);
    assign mem_addr  = waddr_q;
    assign mem_wdata = word_q;
    assign rsp_valid = (state == DONE);
    assign rsp_rdata = rdata_q;
    assign rsp_fault = fault_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural synchronous memory.
// Memory contents are only ever written through the DUT (SW preloads).
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:63];

  int checks;
  int failures;

  mem_access_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_fault  (rsp_fault),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // clock / memory model
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[7:2]];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, follow it to completion, and check latency, memory
  // write activity and response. Called #1 after a clock edge while idle.
  task automatic do_op(input string tag, input logic w, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int exp_lat, input int exp_we,
                       input logic [31:0] exp_wdata,
                       input logic [31:0] exp_rdata, input logic exp_fault);
    int lat;
    int we_cnt;
    int first_we;
    logic [31:0] we_addr;
    logic [31:0] we_data;
    check({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    tick;
    // scramble request inputs; they must not affect the accepted operation
    req_valid  = 1'b0;
    req_write  = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom_range(0, 7));
    req_addr   = $urandom;
    req_wdata  = $urandom;
    lat = 1;
    we_cnt = 0;
    first_we = 0;
    we_addr = 32'h0;
    we_data = 32'h0;
    while (!rsp_valid && lat < 20) begin
      if (mem_we) begin
        we_cnt++;
        we_addr = mem_addr;
        we_data = mem_wdata;
        if (first_we == 0) first_we = lat;
      end
      tick;
      lat++;
    end
    check({tag, " rsp_valid seen"}, 32'(rsp_valid), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " rdata"}, rsp_rdata, exp_rdata);
    check({tag, " fault"}, 32'(rsp_fault), 32'(exp_fault));
    check({tag, " mem_we pulses"}, 32'(we_cnt), 32'(exp_we));
    if (exp_we > 0) begin
      check({tag, " mem_wdata"}, we_data, exp_wdata);
      check({tag, " mem_addr"}, we_addr, {addr[31:2], 2'b00});
      check({tag, " we cycle"}, 32'(first_we), 32'(exp_lat - 1));
    end
    tick;
    check({tag, " rsp pulse"}, 32'(rsp_valid), 32'd0);
    check({tag, " ready after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_funct3 = 3'b000;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    repeat (3) tick;

    // reset state
    check("reset ready", 32'(req_ready), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_fault", 32'(rsp_fault), 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'h0);
    check("reset mem_we", 32'(mem_we), 32'd0);
    rst = 1'b0;
    tick;

    // word store / load
    do_op("sw 0x10", 1'b1, 3'b010, 32'h10, 32'h11223344, 2, 1, 32'h11223344, 32'h0, 1'b0);
    do_op("lw 0x10", 1'b0, 3'b010, 32'h10, 32'h0, 3, 0, 32'h0, 32'h11223344, 1'b0);

    // sub-word loads and extension
    do_op("sw 0x10 b", 1'b1, 3'b010, 32'h10, 32'h80FF7F01, 2, 1, 32'h80FF7F01, 32'h0, 1'b0);
    do_op("lb 0x13", 1'b0, 3'b000, 32'h13, 32'h0, 3, 0, 32'h0, 32'hFFFFFF80, 1'b0);
    do_op("lbu 0x13", 1'b0, 3'b100, 32'h13, 32'h0, 3, 0, 32'h0, 32'h00000080, 1'b0);
    do_op("lh 0x12", 1'b0, 3'b001, 32'h12, 32'h0, 3, 0, 32'h0, 32'hFFFF80FF, 1'b0);
    do_op("lhu 0x12", 1'b0, 3'b101, 32'h12, 32'h0, 3, 0, 32'h0, 32'h000080FF, 1'b0);
    do_op("lb 0x11", 1'b0, 3'b000, 32'h11, 32'h0, 3, 0, 32'h0, 32'h0000007F, 1'b0);
    do_op("lh 0x10", 1'b0, 3'b001, 32'h10, 32'h0, 3, 0, 32'h0, 32'h00007F01, 1'b0);

    // read-modify-write stores
    do_op("sw 0x20", 1'b1, 3'b010, 32'h20, 32'h11223344, 2, 1, 32'h11223344, 32'h0, 1'b0);
    do_op("sb 0x21", 1'b1, 3'b000, 32'h21, 32'hDEADBEAA, 4, 1, 32'h1122AA44, 32'h0, 1'b0);
    do_op("sh 0x22", 1'b1, 3'b001, 32'h22, 32'h00005566, 4, 1, 32'h5566AA44, 32'h0, 1'b0);
    do_op("lw 0x20", 1'b0, 3'b010, 32'h20, 32'h0, 3, 0, 32'h0, 32'h5566AA44, 1'b0);
    do_op("sb 0x23", 1'b1, 3'b000, 32'h23, 32'h000000C3, 4, 1, 32'hC366AA44, 32'h0, 1'b0);

    // SW timing
    do_op("sw 0x30", 1'b1, 3'b010, 32'h30, 32'hCAFEBABE, 2, 1, 32'hCAFEBABE, 32'h0, 1'b0);

    // faults: no memory cycle, memory unchanged
    do_op("lw 0x31 flt", 1'b0, 3'b010, 32'h31, 32'h0, 1, 0, 32'h0, 32'h0, 1'b1);
    do_op("sh 0x33 flt", 1'b1, 3'b001, 32'h33, 32'hFFFF, 1, 0, 32'h0, 32'h0, 1'b1);
    do_op("ld f3=011 flt", 1'b0, 3'b011, 32'h30, 32'h0, 1, 0, 32'h0, 32'h0, 1'b1);
    do_op("sw 0x32 flt", 1'b1, 3'b010, 32'h32, 32'h12345678, 1, 0, 32'h0, 32'h0, 1'b1);
    do_op("st f3=100 flt", 1'b1, 3'b100, 32'h30, 32'h12345678, 1, 0, 32'h0, 32'h0, 1'b1);
    do_op("lw 0x30 after", 1'b0, 3'b010, 32'h30, 32'h0, 3, 0, 32'h0, 32'hCAFEBABE, 1'b0);

    // reset during an SB read-modify-write
    do_op("sw 0x40", 1'b1, 3'b010, 32'h40, 32'hA5A5A5A5, 2, 1, 32'hA5A5A5A5, 32'h0, 1'b0);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_funct3 = 3'b000;
    req_addr = 32'h41;
    req_wdata = 32'h000000FF;
    tick;             // accepted, now RD
    req_valid = 1'b0;
    tick;             // now RD_WAIT
    rst = 1'b1;
    tick;
    check("rst abort mem_we", 32'(mem_we), 32'd0);
    check("rst abort rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst abort ready", 32'(req_ready), 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("post rst quiet", {30'h0, mem_we, rsp_valid}, 32'h0);
      tick;
    end
    do_op("lw 0x40 after rst", 1'b0, 3'b010, 32'h40, 32'h0, 3, 0, 32'h0, 32'hA5A5A5A5, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
